// File: rtl/bpu_update_sched_pkg.sv
// Shared BPU types and defaults: update record, scheduler state
// encoding and the default queue/table sizes.
package bpu_update_sched_pkg;

    localparam int BPU_FIFO_DEPTH   = 4;
    localparam int BPU_INIT_ENTRIES = 1024;

    typedef enum logic [0:0] {
        BPU_SCHED_INIT = 1'b0,
        BPU_SCHED_RUN  = 1'b1
    } bpu_sched_state_e;

    typedef struct packed {
        logic [29:0] pc;
        logic [29:0] br_target;
        logic        taken;
        logic        flush;
    } bpu_update_t;

    function automatic logic [1:0] lane_cnt(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/bpu_update_sched_if.sv
// Resolved-branch feedback in, BPU table write channel and
// front-end redirect out.
interface bpu_update_sched_if
    import bpu_update_sched_pkg::*;
#(
    parameter int IDX_W = 10
);

    logic              upd0_valid_i;
    bpu_update_t       upd0_i;
    logic              upd1_valid_i;
    bpu_update_t       upd1_i;
    logic              stall_o;
    logic              redirect_o;
    logic [29:0]       redirect_pc_o;
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic              wr_init_o;
    logic [IDX_W-1:0]  wr_index_o;
    bpu_update_t       wr_upd_o;

    modport slave (
        input  upd0_valid_i,
        input  upd0_i,
        input  upd1_valid_i,
        input  upd1_i,
        input  wr_ready_i,
        output stall_o,
        output redirect_o,
        output redirect_pc_o,
        output wr_valid_o,
        output wr_init_o,
        output wr_index_o,
        output wr_upd_o
    );

    modport master (
        output upd0_valid_i,
        output upd0_i,
        output upd1_valid_i,
        output upd1_i,
        output wr_ready_i,
        input  stall_o,
        input  redirect_o,
        input  redirect_pc_o,
        input  wr_valid_o,
        input  wr_init_o,
        input  wr_index_o,
        input  wr_upd_o
    );

endinterface

// File: rtl/bpu_upd_fifo.sv
// Two-write / one-read update queue. Payload storage is unreset;
// pointers and occupancy are reset.
module bpu_upd_fifo
    import bpu_update_sched_pkg::*;
#(
    parameter int DEPTH = BPU_FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0,
    input  logic          push1,
    input  bpu_update_t   d0,
    input  bpu_update_t   d1,
    input  logic          pop,
    output bpu_update_t   head,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [1:0]    n_push;
    logic          pop_ok;
    logic [CW-1:0] count_nxt;
    bpu_update_t   mem [DEPTH];

    assign n_push    = lane_cnt(push0, push1);
    assign empty     = (count == '0);
    assign pop_ok    = pop && !empty;
    assign count_nxt = count + CW'(n_push) - CW'(pop_ok);
    assign head      = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(n_push);
            count <= count_nxt;
            if (pop_ok)
                rp <= rp + PW'(1);
        end
    end

    // A lone lane 1 takes the first free slot.
    always_ff @(posedge clk) begin
        if (push0 || push1)
            mem[wp] <= push0 ? d0 : d1;
        if (push0 && push1)
            mem[wp + PW'(1)] <= d1;
    end

endmodule

// File: rtl/bpu_update_sched.sv
// BPU update scheduler: clears the tables after reset, then queues
// resolved-branch updates and raises front-end redirects.
module bpu_update_sched
    import bpu_update_sched_pkg::*;
#(
    parameter int FIFO_DEPTH   = BPU_FIFO_DEPTH,
    parameter int INIT_ENTRIES = BPU_INIT_ENTRIES
) (
    input  logic                clk,
    input  logic                rst_n,
    bpu_update_sched_if.slave   io
);

    localparam int IDX_W = $clog2(INIT_ENTRIES);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_INIT = BPU_SCHED_INIT;
    localparam logic [0:0] ST_RUN  = BPU_SCHED_RUN;

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_cnt;
    logic             in_init;
    logic             stall;
    logic             accept;
    logic             push0;
    logic             push1;
    logic             pop;
    logic             red0;
    logic             red1;
    logic             redirect_q;
    logic [29:0]      redirect_pc_q;
    logic             q_empty;
    logic [CW-1:0]    q_count;
    bpu_update_t      q_head;

    assign in_init = (state == ST_INIT);
    assign stall   = in_init || (q_count > CW'(FIFO_DEPTH - 2));
    assign accept  = !stall;

    // A flushing lane 0 makes lane 1 wrong-path.
    assign push0 = accept && io.upd0_valid_i;
    assign push1 = accept && io.upd1_valid_i
                   && !(io.upd0_valid_i && io.upd0_i.flush);
    assign pop   = !in_init && !q_empty && io.wr_ready_i;

    assign red0 = push0 && io.upd0_i.flush;
    assign red1 = push1 && io.upd1_i.flush;

    bpu_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push0 (push0),
        .push1 (push1),
        .d0    (io.upd0_i),
        .d1    (io.upd1_i),
        .pop   (pop),
        .head  (q_head),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else if (in_init && io.wr_ready_i) begin
            clr_cnt <= clr_cnt + IDX_W'(1);
            if (clr_cnt == IDX_W'(INIT_ENTRIES - 1))
                state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= red0 || red1;
            if (red0)
                redirect_pc_q <= io.upd0_i.br_target;
            else if (red1)
                redirect_pc_q <= io.upd1_i.br_target;
        end
    end

    assign io.stall_o       = stall;
    assign io.redirect_o    = redirect_q;
    assign io.redirect_pc_o = redirect_pc_q;
    assign io.wr_valid_o    = in_init || !q_empty;
    assign io.wr_init_o     = in_init;
    assign io.wr_index_o    = clr_cnt;
    assign io.wr_upd_o      = q_head;

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed bench for bpu_update_sched with a small 8-entry clear.
module tb_bpu_update_sched;
    import bpu_update_sched_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cmp   = 0;
    int   err   = 0;

    bpu_update_sched_if #(.IDX_W(3)) if_u ();

    bpu_update_sched #(
        .FIFO_DEPTH   (4),
        .INIT_ENTRIES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if_u.slave)
    );

    always #5 clk = ~clk;

    function automatic bpu_update_t mk(input logic [29:0] pc,
                                       input logic [29:0] tgt,
                                       input logic fl);
        bpu_update_t u;
        u.pc        = pc;
        u.br_target = tgt;
        u.taken     = fl;
        u.flush     = fl;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_lanes();
        if_u.upd0_valid_i = 1'b0;
        if_u.upd1_valid_i = 1'b0;
        if_u.upd0_i       = '0;
        if_u.upd1_i       = '0;
    endtask

    task automatic test_reset();
        clr_lanes();
        if_u.wr_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        cmp++; if (if_u.wr_valid_o !== 1'b1) begin err++; $display("FAIL rst_wr_valid got %0b want 1", if_u.wr_valid_o); end
        cmp++; if (if_u.wr_init_o !== 1'b1) begin err++; $display("FAIL rst_wr_init got %0b want 1", if_u.wr_init_o); end
        cmp++; if (if_u.wr_index_o !== 3'd0) begin err++; $display("FAIL rst_index got %0d want 0", if_u.wr_index_o); end
        cmp++; if (if_u.stall_o !== 1'b1) begin err++; $display("FAIL rst_stall got %0b want 1", if_u.stall_o); end
        cmp++; if (if_u.redirect_o !== 1'b0) begin err++; $display("FAIL rst_redirect got %0b want 0", if_u.redirect_o); end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_init_toggle();
        logic [2:0] exp_idx [4] = '{3'd0, 3'd1, 3'd1, 3'd2};
        logic       rdy     [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cmp++; if (if_u.wr_index_o !== exp_idx[i]) begin err++; $display("FAIL toggle_index[%0d] got %0d want %0d", i, if_u.wr_index_o, exp_idx[i]); end
            cmp++; if (if_u.stall_o !== 1'b1) begin err++; $display("FAIL toggle_stall[%0d] got %0b want 1", i, if_u.stall_o); end
            if (i < 3) begin
                if_u.wr_ready_i = rdy[i];
                step();
            end
        end
        if_u.wr_ready_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        cmp++; if (if_u.wr_index_o !== 3'd0) begin err++; $display("FAIL midinit_rst_index got %0d want 0", if_u.wr_index_o); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_init_clear();
        if_u.wr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmp++; if (if_u.wr_init_o !== 1'b1 || if_u.wr_valid_o !== 1'b1) begin err++; $display("FAIL clear_init[%0d] got init=%0b valid=%0b want 1/1", i, if_u.wr_init_o, if_u.wr_valid_o); end
            cmp++; if (if_u.wr_index_o !== 3'(i)) begin err++; $display("FAIL clear_index[%0d] got %0d want %0d", i, if_u.wr_index_o, i); end
            step();
        end
        cmp++; if (if_u.wr_init_o !== 1'b0) begin err++; $display("FAIL run_init got %0b want 0", if_u.wr_init_o); end
        cmp++; if (if_u.stall_o !== 1'b0) begin err++; $display("FAIL run_stall got %0b want 0", if_u.stall_o); end
        cmp++; if (if_u.wr_valid_o !== 1'b0) begin err++; $display("FAIL run_wr_valid got %0b want 0", if_u.wr_valid_o); end
        if_u.wr_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp_pc;
        logic        exp_st;
        if_u.wr_ready_i   = 1'b0;
        if_u.upd0_valid_i = 1'b1;
        if_u.upd1_valid_i = 1'b1;
        if_u.upd0_i       = mk(30'h100, 30'h0, 1'b0);
        if_u.upd1_i       = mk(30'h104, 30'h0, 1'b0);
        step();
        cmp++; if (dut.u_fifo.count !== 3'd2) begin err++; $display("FAIL b2b_count2 got %0d want 2", dut.u_fifo.count); end
        cmp++; if (if_u.stall_o !== 1'b0) begin err++; $display("FAIL b2b_stall2 got %0b want 0", if_u.stall_o); end
        cmp++; if (if_u.wr_upd_o.pc !== 30'h100) begin err++; $display("FAIL b2b_head2 got %0h want 100", if_u.wr_upd_o.pc); end
        step();
        clr_lanes();
        cmp++; if (dut.u_fifo.count !== 3'd4) begin err++; $display("FAIL b2b_count4 got %0d want 4", dut.u_fifo.count); end
        cmp++; if (if_u.wr_upd_o.pc !== 30'h100) begin err++; $display("FAIL b2b_head_hold got %0h want 100", if_u.wr_upd_o.pc); end
        if_u.wr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = (i % 2 == 1) ? 30'h104 : 30'h100;
            exp_st = (4 - i) > 2;
            cmp++; if (if_u.wr_valid_o !== 1'b1 || if_u.wr_upd_o.pc !== exp_pc) begin err++; $display("FAIL drain[%0d] got v=%0b pc=%0h want 1/%0h", i, if_u.wr_valid_o, if_u.wr_upd_o.pc, exp_pc); end
            cmp++; if (if_u.stall_o !== exp_st) begin err++; $display("FAIL drain_stall[%0d] got %0b want %0b", i, if_u.stall_o, exp_st); end
            step();
        end
        cmp++; if (if_u.wr_valid_o !== 1'b0 || dut.u_fifo.count !== 3'd0) begin err++; $display("FAIL drained got v=%0b cnt=%0d want 0/0", if_u.wr_valid_o, dut.u_fifo.count); end
        if_u.wr_ready_i = 1'b0;
    endtask

    task automatic test_flush_drop();
        if_u.upd0_valid_i = 1'b1;
        if_u.upd1_valid_i = 1'b1;
        if_u.upd0_i       = mk(30'h200, 30'h2000, 1'b1);
        if_u.upd1_i       = mk(30'h204, 30'h0, 1'b0);
        cmp++; if (if_u.redirect_o !== 1'b0) begin err++; $display("FAIL drop_pre_redirect got %0b want 0", if_u.redirect_o); end
        step();
        clr_lanes();
        cmp++; if (dut.u_fifo.count !== 3'd1) begin err++; $display("FAIL drop_count got %0d want 1", dut.u_fifo.count); end
        cmp++; if (if_u.redirect_o !== 1'b1 || if_u.redirect_pc_o !== 30'h2000) begin err++; $display("FAIL drop_redirect got %0b/%0h want 1/2000", if_u.redirect_o, if_u.redirect_pc_o); end
        cmp++; if (if_u.wr_upd_o.pc !== 30'h200) begin err++; $display("FAIL drop_head got %0h want 200", if_u.wr_upd_o.pc); end
        step();
        cmp++; if (if_u.redirect_o !== 1'b0 || if_u.redirect_pc_o !== 30'h2000) begin err++; $display("FAIL drop_pulse_end got %0b/%0h want 0/2000", if_u.redirect_o, if_u.redirect_pc_o); end
    endtask

    task automatic test_lane1_flush();
        if_u.upd0_valid_i = 1'b1;
        if_u.upd1_valid_i = 1'b1;
        if_u.upd0_i       = mk(30'h300, 30'h0, 1'b0);
        if_u.upd1_i       = mk(30'h304, 30'h3000, 1'b1);
        step();
        clr_lanes();
        cmp++; if (dut.u_fifo.count !== 3'd3) begin err++; $display("FAIL l1f_count got %0d want 3", dut.u_fifo.count); end
        cmp++; if (if_u.redirect_o !== 1'b1 || if_u.redirect_pc_o !== 30'h3000) begin err++; $display("FAIL l1f_redirect got %0b/%0h want 1/3000", if_u.redirect_o, if_u.redirect_pc_o); end
        step();
        cmp++; if (if_u.stall_o !== 1'b1) begin err++; $display("FAIL full_stall got %0b want 1", if_u.stall_o); end
        if_u.upd0_valid_i = 1'b1;
        if_u.upd0_i       = mk(30'h400, 30'h4000, 1'b1);
        step();
        clr_lanes();
        cmp++; if (dut.u_fifo.count !== 3'd3) begin err++; $display("FAIL stalled_count got %0d want 3", dut.u_fifo.count); end
        cmp++; if (if_u.redirect_o !== 1'b0 || if_u.redirect_pc_o !== 30'h3000) begin err++; $display("FAIL stalled_redirect got %0b/%0h want 0/3000", if_u.redirect_o, if_u.redirect_pc_o); end
    endtask

    task automatic test_reset_run();
        #3 rst_n = 1'b0;
        #1;
        cmp++; if (if_u.wr_init_o !== 1'b1 || if_u.wr_valid_o !== 1'b1) begin err++; $display("FAIL runrst_init got %0b/%0b want 1/1", if_u.wr_init_o, if_u.wr_valid_o); end
        cmp++; if (if_u.wr_index_o !== 3'd0 || dut.u_fifo.count !== 3'd0) begin err++; $display("FAIL runrst_idx_cnt got %0d/%0d want 0/0", if_u.wr_index_o, dut.u_fifo.count); end
        cmp++; if (if_u.redirect_pc_o !== 30'h0 || if_u.stall_o !== 1'b1) begin err++; $display("FAIL runrst_pc_stall got %0h/%0b want 0/1", if_u.redirect_pc_o, if_u.stall_o); end
        step();
        rst_n = 1'b1;
        if_u.wr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmp++; if (if_u.wr_init_o !== 1'b1 || if_u.wr_index_o !== 3'(i)) begin err++; $display("FAIL reclear[%0d] got init=%0b idx=%0d want 1/%0d", i, if_u.wr_init_o, if_u.wr_index_o, i); end
            step();
        end
        cmp++; if (if_u.wr_valid_o !== 1'b0 || dut.u_fifo.count !== 3'd0) begin err++; $display("FAIL no_stale got v=%0b cnt=%0d want 0/0", if_u.wr_valid_o, dut.u_fifo.count); end
    endtask

    task automatic test_lane1_alone();
        if_u.wr_ready_i   = 1'b0;
        if_u.upd1_valid_i = 1'b1;
        if_u.upd1_i       = mk(30'h500, 30'h0, 1'b0);
        step();
        clr_lanes();
        cmp++; if (dut.u_fifo.count !== 3'd1 || if_u.wr_upd_o.pc !== 30'h500) begin err++; $display("FAIL l1_alone got cnt=%0d pc=%0h want 1/500", dut.u_fifo.count, if_u.wr_upd_o.pc); end
        cmp++; if (if_u.wr_valid_o !== 1'b1) begin err++; $display("FAIL l1_valid got %0b want 1", if_u.wr_valid_o); end
        if_u.wr_ready_i = 1'b1;
        step();
        cmp++; if (if_u.wr_valid_o !== 1'b0 || dut.u_fifo.count !== 3'd0) begin err++; $display("FAIL l1_pop got v=%0b cnt=%0d want 0/0", if_u.wr_valid_o, dut.u_fifo.count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_toggle();
        test_init_clear();
        test_back_to_back();
        test_flush_drop();
        test_lane1_flush();
        test_reset_run();
        test_lane1_alone();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/bpu_update_sched.md
BPU_UPDATE_SCHED -- requirements
Module: bpu_update_sched

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the update queue depth (power of two, at least 2).
REQ-002 The block SHALL have parameter INIT_ENTRIES, default 1024, meaning the number of table indices cleared after reset (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port upd0_valid_i, input, 1 bit: lane-0 (older) branch resolved.
REQ-006 The block SHALL have port upd0_i, input, bpu_update_t: lane-0 feedback record.
REQ-007 The block SHALL have port upd1_valid_i, input, 1 bit: lane-1 (younger) branch resolved.
REQ-008 The block SHALL have port upd1_i, input, bpu_update_t: lane-1 feedback record.
REQ-009 The block SHALL have port stall_o, output, 1 bit: updates are not accepted this cycle, and the upstream holds them.
REQ-010 The block SHALL have port redirect_o, output, 1 bit: front-end redirect pulse.
REQ-011 The block SHALL have port redirect_pc_o, output, 30 bits: redirect target [31:2].
REQ-012 The block SHALL have port wr_valid_o, output, 1 bit: table write request.
REQ-013 The block SHALL have port wr_ready_i, input, 1 bit: the BPU tables accept the write.
REQ-014 The block SHALL have port wr_init_o, output, 1 bit: the write is an init-clear, not an update.
REQ-015 The block SHALL have port wr_index_o, output, log2(INIT_ENTRIES) bits: the clear index.
REQ-016 The block SHALL have port wr_upd_o, output, bpu_update_t: the update record to write.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN; reset SHALL enter INIT.
REQ-018 In INIT the block SHALL drive wr_valid_o=1, wr_init_o=1, and wr_index_o=the clear counter.
REQ-019 In INIT the counter SHALL increment only on wr_ready_i.
REQ-020 In INIT, when the counter reaches INIT_ENTRIES-1 and wr_ready_i=1, the FSM SHALL move to RUN next cycle.
REQ-021 In INIT, stall_o SHALL be 1 and no update SHALL be enqueued.
REQ-022 In RUN, stall_o SHALL be 1 iff the free entries number fewer than 2; this SHALL be combinational from the occupancy count.
REQ-023 Accept condition: when stall_o=0, each valid lane SHALL be enqueued in the same cycle, lane 0 before lane 1.
REQ-024 When stall_o=1, no lane SHALL be enqueued.
REQ-025 Wrong-path drop: if upd0_valid_i and upd0_i.flush, lane 1 SHALL be discarded, not enqueued.
REQ-026 Lane 1 alone SHALL enqueue into the first free slot.
REQ-027 Dequeue: in RUN, wr_valid_o SHALL equal (queue non-empty), wr_init_o=0, and wr_upd_o=the head entry.
REQ-028 The head SHALL pop only when wr_valid_o and wr_ready_i are both 1, and the head SHALL remain stable while it is stalled.
REQ-029 When enqueue and dequeue happen in the same cycle, count_next SHALL equal count + enq(0..2) - deq(0..1); enqueue into a slot freed that cycle is not required.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-031 The count SHALL be log2(FIFO_DEPTH)+1 bits and SHALL never exceed FIFO_DEPTH.
REQ-032 The entry selected for redirect is the oldest accepted entry with flush=1 (lane 0 has priority).
REQ-033 On a cycle that accepts such an entry, redirect_o SHALL pulse high for exactly one cycle, registered in the cycle after acceptance, with redirect_pc_o=br_target of that entry.
REQ-034 When there is no redirect, redirect_pc_o SHALL hold its last value.
REQ-035 Redirect SHALL be independent of queue drain: a redirect is never delayed by wr_ready_i.

Reset
REQ-036 Asynchronous assertion of rst_n SHALL clear the FSM to INIT, the clear counter, pointers, count, redirect_o, and redirect_pc_o to 0.
REQ-037 During reset, outputs SHALL be: wr_valid_o=1 (INIT), wr_init_o=1, wr_index_o=0, stall_o=1, and redirect_o=0.
REQ-038 Queue payload storage SHALL need no reset.
REQ-039 If reset is asserted mid-INIT or in RUN with entries queued, all state SHALL be discarded and the clear SHALL restart from index 0.

Structure
REQ-040 bpu_update_t and the state enum (BPU_SCHED_INIT, BPU_SCHED_RUN) SHALL live in the shared bpu package header.
REQ-041 FIFO_DEPTH and INIT_ENTRIES defaults SHALL be package constants.
REQ-042 The queue SHALL be one sub-module, bpu_upd_fifo: a 2-write/1-read FIFO with its own count and pointers, and the FSM and redirect logic SHALL live in the top.

Verification
REQ-043 Scenario: INIT_ENTRIES=8, wr_ready_i held 1 after reset -> wr_init_o=1 with wr_index_o 0..7 over 8 cycles, then RUN, stall_o=0, wr_valid_o=0.
REQ-044 Scenario: in INIT, wr_ready_i toggles 1,0,1 -> the index advances 0,1,1,2, and stall_o=1 throughout.
REQ-045 Scenario: RUN, both lanes valid, pc 0x100/0x104, no flush, wr_ready_i=0 -> count 2; next cycle same again -> count 4, stall_o=1; then wr_ready_i=1 -> writes 0x100,0x104,0x100,0x104 in order, and stall_o drops when count ≤2.
REQ-046 Scenario: lane0 flush=1 with br_target 0x2000, lane1 valid -> only lane 0 is enqueued (count+1), and redirect_o=1 next cycle with redirect_pc_o=0x2000, for one cycle.
REQ-047 Scenario: lane0 valid with no flush, lane1 flush=1 with br_target 0x3000 -> both are enqueued, and redirect_pc_o=0x3000.
REQ-048 Scenario: rst_n asserted with 3 entries queued and wr_ready_i=0 -> the FSM returns to INIT immediately, wr_index_o=0, count=0, and no queued update is written afterward.
